// File: rtl/line_move_pkg.sv
// Shared types and default bounds for the line position tracker.
package line_move_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        MV_UP = 2'd1,
        MV_DN = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        CL_UP = 2'd0,
        CL_DN = 2'd1,
        CL_LD = 2'd2
    } clamp_op_t;

    localparam int LINE_MIN_DEF = 18;
    localparam int LINE_MAX_DEF = 487;

endpackage

// File: rtl/line_bound_clamp.sv
// Combinational add/subtract/clamp against [MIN_POS, MAX_POS], done in WIDTH+1 bits
// so neither the step add nor the bound compare can wrap.
module line_bound_clamp
    import line_move_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int STEP_W  = 4,
    parameter int MIN_POS = LINE_MIN_DEF,
    parameter int MAX_POS = LINE_MAX_DEF
) (
    input  clamp_op_t          op,
    input  logic [WIDTH-1:0]   base,
    input  logic [STEP_W-1:0]  step,
    output logic [WIDTH-1:0]   res
);

    localparam logic [WIDTH:0]   MINX = (WIDTH+1)'(MIN_POS);
    localparam logic [WIDTH:0]   MAXX = (WIDTH+1)'(MAX_POS);
    localparam logic [WIDTH-1:0] QMIN = WIDTH'(MIN_POS);
    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MAX_POS);

    logic [WIDTH:0] ext, stx, sum;

    always_comb begin
        ext = {1'b0, base};
        stx = (WIDTH+1)'(step);
        sum = ext + stx;
        res = base;
        case (op)
            CL_UP:   res = (sum > MAXX) ? QMAX : WIDTH'(sum);
            CL_DN:   res = (ext < MINX + stx) ? QMIN : WIDTH'(ext - stx);
            CL_LD:   res = (ext > MAXX) ? QMAX : ((ext < MINX) ? QMIN : base);
            default: res = base;
        endcase
    end

endmodule

// File: rtl/line_pos_tracker.sv
// Line coordinate tracker: latched direction FSM, clamped tick moves and clamped load.
// Define LINE_BOUNCE_EN to reverse direction on a bound hit instead of holding.
module line_pos_tracker
    import line_move_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MIN_POS   = LINE_MIN_DEF,
    parameter int MAX_POS   = LINE_MAX_DEF,
    parameter int RESET_POS = LINE_MIN_DEF,
    parameter int STEP_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              UP,
    input  logic              DW,
    input  logic              LD,
    input  logic              tick,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  D,
    output logic [WIDTH-1:0]  Q,
    output logic [1:0]        dir,
    output logic              at_max,
    output logic              at_min,
    output logic              hit
);

    localparam logic [WIDTH-1:0] QMIN = WIDTH'(MIN_POS);
    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MAX_POS);
    localparam logic [WIDTH-1:0] QRST = WIDTH'(RESET_POS);

    dir_t             st, st_nxt;
    logic [WIDTH-1:0] mv_res, ld_res, q_nxt;
    logic             mv, hit_nxt;
    clamp_op_t        mv_op;

    assign mv_op = (st == MV_DN) ? CL_DN : CL_UP;

    line_bound_clamp #(.WIDTH(WIDTH), .STEP_W(STEP_W), .MIN_POS(MIN_POS), .MAX_POS(MAX_POS))
        u_mv_clamp (.op(mv_op), .base(Q), .step(step), .res(mv_res));

    line_bound_clamp #(.WIDTH(WIDTH), .STEP_W(STEP_W), .MIN_POS(MIN_POS), .MAX_POS(MAX_POS))
        u_ld_clamp (.op(CL_LD), .base(D), .step('0), .res(ld_res));

    always_comb begin
        mv      = tick && !LD && (st != HOLD) && (step != '0);
        q_nxt   = Q;
        hit_nxt = 1'b0;
        if (LD) begin
            q_nxt = ld_res;
        end else if (mv) begin
            q_nxt   = mv_res;
            hit_nxt = (st == MV_UP) ? (mv_res == QMAX) : (mv_res == QMIN);
        end

        // bound reaction first, so a same-cycle command overrides it
        st_nxt = st;
        if (hit_nxt) begin
`ifdef LINE_BOUNCE_EN
            st_nxt = (st == MV_UP) ? MV_DN : MV_UP;
`else
            st_nxt = HOLD;
`endif
        end
        if (UP && !DW)      st_nxt = MV_UP;
        else if (DW && !UP) st_nxt = MV_DN;
        else if (UP && DW)  st_nxt = HOLD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Q   <= QRST;
            st  <= HOLD;
            hit <= 1'b0;
        end else begin
            Q   <= q_nxt;
            st  <= st_nxt;
            hit <= hit_nxt;
        end
    end

    assign dir    = st;
    assign at_max = (Q == QMAX);
    assign at_min = (Q == QMIN);

endmodule

// File: doc/line_pos_tracker.md
# line_pos_tracker

Parametrised line-position tracker that generalises the fixed 16-bit cascaded line-move counter. It holds one line coordinate, moves it by a programmable step on a frame tick in a latched direction, and clamps to configurable bounds. It sits between the button/switch input logic and the VGA line renderer, supplying the renderer's Y (or X) coordinate and boundary flags.

## Interface
- WIDTH, 16: coordinate width in bits.
- MIN_POS, 18: lower bound (inclusive); must satisfy MIN_POS <= MAX_POS < 2^WIDTH.
- MAX_POS, 487: upper bound (inclusive).
- RESET_POS, 18: position after reset; must lie in [MIN_POS, MAX_POS].
- STEP_W, 4: width of the step input.

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- UP  in  1  level; direction command "move up", sampled every cycle.
- DW  in  1  level; direction command "move down", sampled every cycle.
- LD  in  1  load D into position, clamped.
- tick  in  1  one-cycle frame strobe; a move happens only on tick.
- step  in  STEP_W  step size per tick; 0 means no movement.
- D  in  WIDTH  load value.
- Q  out  WIDTH  current position (registered).
- dir  out  2  current direction state: 0 = HOLD, 1 = MV_UP, 2 = MV_DN.
- at_max  out  1  Q == MAX_POS (combinational from Q).
- at_min  out  1  Q == MIN_POS (combinational from Q).
- hit  out  1  one-cycle pulse, registered, when a tick move lands on a bound.

## Operation
- Direction FSM, states HOLD / MV_UP / MV_DN, reset state HOLD.
- Command decode per cycle: UP & ~DW -> MV_UP; DW & ~UP -> MV_DN; UP & DW -> HOLD; neither -> state unchanged.
- Priority: reset > LD > tick move. On the LD cycle, Q <= clamp(D); the tick is ignored; direction commands still update the FSM.
- Move on tick in MV_UP: Q <= min(Q + step, MAX_POS). Sum is computed in WIDTH+1 bits, so no wrap.
- Move on tick in MV_DN: Q <= MIN_POS if Q < MIN_POS + step (WIDTH+1-bit compare), else Q - step.
- Move on tick in HOLD, or with step == 0: Q unchanged, hit = 0.
- The direction used for a move is the registered state at the tick, not the same-cycle command.
- hit <= 1 when a tick move in MV_UP or MV_DN changes Q, or leaves Q already at the bound it is heading into, with the result equal to that bound. Otherwise hit <= 0.
- On reaching the bound without LINE_BOUNCE_EN, the FSM goes to HOLD on the same edge, unless a command that cycle overrides it.
- Reset values: Q = RESET_POS, dir = HOLD, hit = 0. at_max and at_min follow from RESET_POS.

## Timing
- Single clock domain, no combinational input-to-output path except the flags, which follow Q.
- Q, dir and hit update on the edge that samples tick/LD/commands; latency 1 cycle.
- hit is high in the same cycle Q first shows the bound value.
- Reset mid-move: the next edge forces the reset values regardless of tick, LD or commands.
- tick held high for several cycles moves once per cycle; no edge detect is applied to tick.

## Configuration
- LINE_BOUNCE_EN defined: on a bound hit, the FSM reverses (MV_UP -> MV_DN, MV_DN -> MV_UP) instead of going to HOLD. A same-cycle explicit command still wins. hit is still pulsed.
- LINE_BOUNCE_EN undefined: a bound hit goes to HOLD as described above.

## Structure
- Package line_move_pkg: dir_t enum (HOLD, MV_UP, MV_DN), default bound constants LINE_MIN_DEF = 18 and LINE_MAX_DEF = 487.
- Sub-module line_bound_clamp: combinational WIDTH+1-bit add/subtract/clamp, used for both the move path and the LD path.

## Test plan
- Reset, then idle 5 cycles -> Q = 18, dir = HOLD, at_min = 1, hit = 0.
- UP for 1 cycle, step = 3, 4 ticks -> Q = 21, 24, 27, 30; dir = MV_UP throughout.
- LD with D = 480, then MV_UP, step = 5, two ticks -> Q = 485, then 487 with hit = 1 and at_max = 1. Without the macro dir = HOLD; with the macro dir = MV_DN.
- LD with D = 5 -> Q = 18. LD with D = 600 -> Q = 487. LD and tick in the same cycle -> only the load takes effect.
- UP and DW asserted together during MV_DN -> dir = HOLD; subsequent ticks leave Q unchanged.
- Reset asserted on a tick cycle while in MV_DN at Q = 100 -> next cycle Q = 18, dir = HOLD, hit = 0.
